vid_pattern_gen: RTL

Video test-pattern source that sits directly downstream of the video timing generator. It consumes the generator's DE/HS/VS, VS_STROBE and H_CNT/V_CNT, and produces timing-aligned 24-bit RGB for the DVI transmitter path. It measures the active raster itself, so it needs no resolution inputs. It also keeps a frame counter and an animated bouncing box for visual and link checks.

---
 rtl/vid_pattern_gen.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/vid_pattern_gen.sv
// Test-pattern source for the DVI path: re-times DE/HS/VS by two cycles and
// paints one of several patterns, measuring the raster and animating a box.
module vid_pattern_gen #(
    parameter int BOX_MAX = 255
) (
    input  logic        PIX_CLK,
    input  logic        RESET_N,
    input  logic        DE_IN,
    input  logic        HS_IN,
    input  logic        VS_IN,
    input  logic        VS_STROBE_IN,
    input  logic [10:0] H_CNT,
    input  logic [10:0] V_CNT,
    input  logic [2:0]  PATTERN_SEL,
    input  logic [23:0] FG_COLOR,
    input  logic [7:0]  BOX_SIZE,
    output logic        DE,
    output logic        HS,
    output logic        VS,
    output logic [7:0]  RED,
    output logic [7:0]  GREEN,
    output logic [7:0]  BLUE,
    output logic [10:0] ACT_W,
    output logic [10:0] ACT_H,
    output logic [15:0] FRAME_CNT
);

    localparam logic [2:0]  PAT_SOLID  = 3'd0;
    localparam logic [2:0]  PAT_BARS   = 3'd1;
    localparam logic [2:0]  PAT_CHECK  = 3'd2;
    localparam logic [2:0]  PAT_RAMP   = 3'd3;
    localparam logic [2:0]  PAT_BOX    = 3'd4;
    localparam logic [2:0]  PAT_BORDER = 3'd5;
    localparam logic [10:0] CNT_MAX    = 11'h7FF;
    localparam logic [7:0]  BOX_LIM    = 8'(BOX_MAX);
    localparam logic [23:0] WHITE      = 24'hFFFFFF;

    logic        de_s1;
    logic        hs_s1;
    logic        vs_s1;
    logic [10:0] h_s1;
    logic [10:0] v_s1;

    logic [10:0] run_cnt;
    logic [10:0] line_cnt;
    logic [10:0] line_nxt;
    logic        de_fall;
    logic [2:0]  pat_act;

    logic [10:0] box_x;
    logic [10:0] box_y;
    logic        dx_neg;
    logic        dy_neg;
    logic [7:0]  box_eff;
    logic [10:0] x_lim;
    logic [10:0] y_lim;
    logic [11:0] x_step;
    logic [11:0] y_step;

    logic [11:0] x_end;
    logic [11:0] y_end;
    logic        in_box;
    logic        on_border;
    logic [23:0] pix;

    // Largest legal origin along one axis so the box stays inside the raster.
    function automatic logic [10:0] span_lim(input logic [10:0] act, input logic [7:0] sz);
        logic [10:0] sz_w;
        sz_w = {3'b000, sz};
        return (act > sz_w) ? (act - sz_w) : 11'd0;
    endfunction

    // Returns {new_dir_neg, new_pos} for one bounce step along one axis.
    function automatic logic [11:0] bounce(input logic [10:0] pos, input logic neg,
                                           input logic [10:0] lim);
        logic [10:0] p;
        logic        n;
        p = pos;
        n = neg;
        if (!neg) begin
            if (pos >= lim) begin
                n = 1'b1;
                p = (pos != 11'd0) ? (pos - 11'd1) : 11'd0;
            end else begin
                p = pos + 11'd1;
            end
        end else if (pos == 11'd0) begin
            n = 1'b0;
            p = (lim != 11'd0) ? 11'd1 : 11'd0;
        end else begin
            p = pos - 11'd1;
        end
        return {n, p};
    endfunction

    // Stage 1: plain registration of the timing stream.
    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            de_s1 <= 1'b0;
            hs_s1 <= 1'b0;
            vs_s1 <= 1'b0;
            h_s1  <= '0;
            v_s1  <= '0;
        end else begin
            de_s1 <= DE_IN;
            hs_s1 <= HS_IN;
            vs_s1 <= VS_IN;
            h_s1  <= H_CNT;
            v_s1  <= V_CNT;
        end
    end

    assign de_fall  = de_s1 & ~DE_IN;
    assign line_nxt = (line_cnt == CNT_MAX) ? CNT_MAX : (line_cnt + 11'd1);

    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            run_cnt <= '0;
            ACT_W   <= '0;
        end else begin
            if (DE_IN) begin
                run_cnt <= (run_cnt == CNT_MAX) ? CNT_MAX : (run_cnt + 11'd1);
            end else begin
                run_cnt <= '0;
            end
            if (de_fall) begin
                ACT_W <= run_cnt;
            end
        end
    end

    // A line ending on the strobe edge still belongs to the frame being closed.
    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            line_cnt  <= '0;
            ACT_H     <= '0;
            FRAME_CNT <= '0;
            pat_act   <= PAT_SOLID;
        end else if (VS_STROBE_IN) begin
            ACT_H     <= de_fall ? line_nxt : line_cnt;
            line_cnt  <= '0;
            FRAME_CNT <= FRAME_CNT + 16'd1;
            pat_act   <= PATTERN_SEL;
        end else if (de_fall) begin
            line_cnt <= line_nxt;
        end
    end

    assign box_eff = (BOX_SIZE > BOX_LIM) ? BOX_LIM : BOX_SIZE;
    assign x_lim   = span_lim(ACT_W, box_eff);
    assign y_lim   = span_lim(ACT_H, box_eff);
    assign x_step  = bounce(box_x, dx_neg, x_lim);
    assign y_step  = bounce(box_y, dy_neg, y_lim);

    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            box_x  <= '0;
            box_y  <= '0;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
        end else if (VS_STROBE_IN) begin
            box_x  <= x_step[10:0];
            dx_neg <= x_step[11];
            box_y  <= y_step[10:0];
            dy_neg <= y_step[11];
        end
    end

    // Stage 2 pattern decode; 12-bit box bounds cannot wrap.
    assign x_end  = {1'b0, box_x} + {4'b0000, box_eff};
    assign y_end  = {1'b0, box_y} + {4'b0000, box_eff};
    assign in_box = ({1'b0, h_s1} >= {1'b0, box_x}) && ({1'b0, h_s1} < x_end) &&
                    ({1'b0, v_s1} >= {1'b0, box_y}) && ({1'b0, v_s1} < y_end);
    assign on_border = (ACT_W != 11'd0) && (ACT_H != 11'd0) &&
                       ((h_s1 == 11'd0) || (h_s1 == (ACT_W - 11'd1)) ||
                        (v_s1 == 11'd0) || (v_s1 == (ACT_H - 11'd1)));

    always_comb begin
        pix = '0;
        case (pat_act)
            PAT_SOLID:  pix = FG_COLOR;
            PAT_BARS: begin
                // Bar index h[9:7]: R off for bars 2,3,6,7; G off for 4-7; B off for odd bars.
                if (!h_s1[10]) begin
                    pix = {{8{~h_s1[8]}}, {8{~h_s1[9]}}, {8{~h_s1[7]}}};
                end
            end
            PAT_CHECK:  pix = (h_s1[5] ^ v_s1[5]) ? FG_COLOR : 24'h000000;
            PAT_RAMP:   pix = {h_s1[7:0], h_s1[7:0], h_s1[7:0]};
            PAT_BOX:    pix = in_box ? FG_COLOR : 24'h000000;
            PAT_BORDER: pix = on_border ? WHITE : 24'h000000;
            default:    pix = '0;
        endcase
        if (!de_s1) begin
            pix = '0;
        end
    end

    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DE    <= 1'b0;
            HS    <= 1'b0;
            VS    <= 1'b0;
            RED   <= '0;
            GREEN <= '0;
            BLUE  <= '0;
        end else begin
            DE    <= de_s1;
            HS    <= hs_s1;
            VS    <= vs_s1;
            RED   <= pix[23:16];
            GREEN <= pix[15:8];
            BLUE  <= pix[7:0];
        end
    end

endmodule
